// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and a synchronous single-port memory.
// The master side is the requesters plus memory; the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [DW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_ack;

    logic          dma_req;
    logic          dma_we;
    logic [DW-1:0] dma_adr;
    logic [DW-1:0] dma_wd;
    logic [DW-1:0] dma_rd;
    logic          dma_ack;

    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic          grant_dma;

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  cpu_rd, cpu_ack,
        output dma_req, dma_we, dma_adr, dma_wd,
        input  dma_rd, dma_ack,
        input  mem_en, mem_we, mem_adr, mem_wd,
        output mem_rd,
        input  grant_dma
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        output cpu_rd, cpu_ack,
        input  dma_req, dma_we, dma_adr, dma_wd,
        output dma_rd, dma_ack,
        output mem_en, mem_we, mem_adr, mem_wd,
        input  mem_rd,
        output grant_dma
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a synchronous single-port memory.
// CPU has priority; DMA is forced in after CPU_MAX consecutive CPU grants while it waits.
module mem_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned CPU_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned SW = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [DW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic          grant_dma_q, grant_dma_d;

    logic          req_any;
    logic          pick_dma;
    logic          sel_we;
    logic [DW-1:0] sel_adr;
    logic [DW-1:0] sel_wd;

    // Winner selection, only consumed in IDLE
    always_comb begin
        req_any  = bus.cpu_req | bus.dma_req;
        pick_dma = bus.dma_req & (~bus.cpu_req | (starve_q == SW'(CPU_MAX)));
        sel_we   = pick_dma ? bus.dma_we  : bus.cpu_we;
        sel_adr  = pick_dma ? bus.dma_adr : bus.cpu_adr;
        sel_wd   = pick_dma ? bus.dma_wd  : bus.cpu_wd;
    end

    // Next state, latched access and next registered outputs
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wd_d        = wd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_adr_d   = '0;
        mem_wd_d    = '0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        grant_dma_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Starvation counter only moves on arbitration cycles
                if (!bus.dma_req || pick_dma) begin
                    starve_d = '0;
                end else if (bus.cpu_req && (starve_q < SW'(CPU_MAX))) begin
                    starve_d = starve_q + SW'(1);
                end

                if (req_any) begin
                    state_d     = ISSUE;
                    owner_d     = pick_dma;
                    we_d        = sel_we;
                    adr_d       = sel_adr;
                    wd_d        = sel_wd;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_adr_d   = sel_adr;
                    mem_wd_d    = sel_wd;
                    grant_dma_d = pick_dma;
                end
            end
            ISSUE: begin
                state_d     = RESP;
                cpu_ack_d   = ~owner_q;
                dma_ack_d   = owner_q;
                grant_dma_d = owner_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wd_q        <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wd_q    <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            grant_dma_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wd_q        <= wd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wd_q    <= mem_wd_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            grant_dma_q <= grant_dma_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.grant_dma = grant_dma_q;

    // Memory data arrives in RESP, so read data is passed through gated by the ack
    assign bus.cpu_rd = (cpu_ack_q && !we_q) ? bus.mem_rd : '0;
    assign bus.dma_rd = (dma_ack_q && !we_q) ? bus.mem_rd : '0;

    // Latched address/data are kept for visibility of the in-flight access
    logic unused_ok;
    assign unused_ok = ^{adr_q, wd_q};
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU/DMA accesses, priority, starvation, capture and reset abort.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if #(.DW(32)) bus ();

    mem_arbiter #(.DW(32), .CPU_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory model
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_adr[7:0]] <= bus.mem_wd;
            bus.mem_rd <= mem[bus.mem_adr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10]  = 32'hDEADBEEF;
        bus.mem_rd  = 32'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h0; bus.cpu_wd = 32'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_adr = 32'h0; bus.dma_wd = 32'h0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        check("rst_mem_en",  32'(bus.mem_en), 32'h0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        check("rst_dma_ack", 32'(bus.dma_ack), 32'h0);
        check("rst_grant",   32'(bus.grant_dma), 32'h0);
        check("rst_mem_adr", bus.mem_adr, 32'h0);

        // CPU read of 0x10, address changed during ISSUE
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h10;
        tick();
        check("rd_issue_en",  32'(bus.mem_en), 32'h1);
        check("rd_issue_we",  32'(bus.mem_we), 32'h0);
        bus.cpu_adr = 32'h20;
        #1;
        check("rd_issue_adr", bus.mem_adr, 32'h10);
        tick();
        check("rd_resp_ack",  32'(bus.cpu_ack), 32'h1);
        check("rd_resp_rd",   bus.cpu_rd, 32'hDEADBEEF);
        check("rd_resp_dack", 32'(bus.dma_ack), 32'h0);
        check("rd_resp_en",   32'(bus.mem_en), 32'h0);
        tick();
        bus.cpu_req = 1'b0;
        check("rd_idle_ack",  32'(bus.cpu_ack), 32'h0);
        check("rd_idle_rd",   bus.cpu_rd, 32'h0);

        // DMA write of 0x12345678 to 0x40
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_adr = 32'h40; bus.dma_wd = 32'h12345678;
        tick();
        check("wr_issue_en",    32'(bus.mem_en), 32'h1);
        check("wr_issue_we",    32'(bus.mem_we), 32'h1);
        check("wr_issue_adr",   bus.mem_adr, 32'h40);
        check("wr_issue_wd",    bus.mem_wd, 32'h12345678);
        check("wr_issue_grant", 32'(bus.grant_dma), 32'h1);
        tick();
        check("wr_resp_ack",  32'(bus.dma_ack), 32'h1);
        check("wr_resp_rd",   bus.dma_rd, 32'h0);
        check("wr_resp_cack", 32'(bus.cpu_ack), 32'h0);
        tick();
        bus.dma_req = 1'b0;
        check("wr_idle_grant", 32'(bus.grant_dma), 32'h0);
        check("wr_idle_en",    32'(bus.mem_en), 32'h0);

        // Simultaneous reads: CPU first, DMA at +4/+5
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h40;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_adr = 32'h10; bus.dma_wd = 32'h0;
        tick();
        check("sim1_en",    32'(bus.mem_en), 32'h1);
        check("sim1_adr",   bus.mem_adr, 32'h40);
        check("sim1_grant", 32'(bus.grant_dma), 32'h0);
        tick();
        check("sim2_cack", 32'(bus.cpu_ack), 32'h1);
        check("sim2_crd",  bus.cpu_rd, 32'h12345678);
        check("sim2_dack", 32'(bus.dma_ack), 32'h0);
        tick();
        bus.cpu_req = 1'b0;
        check("sim3_en", 32'(bus.mem_en), 32'h0);
        tick();
        check("sim4_en",    32'(bus.mem_en), 32'h1);
        check("sim4_adr",   bus.mem_adr, 32'h10);
        check("sim4_grant", 32'(bus.grant_dma), 32'h1);
        tick();
        check("sim5_dack", 32'(bus.dma_ack), 32'h1);
        check("sim5_drd",  bus.dma_rd, 32'hDEADBEEF);
        check("sim5_cack", 32'(bus.cpu_ack), 32'h0);
        tick();
        bus.dma_req = 1'b0;

        // Starvation: CPU writes back to back while DMA waits
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_adr = 32'h10;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_adr = 32'h20 + 32'(i);
            bus.cpu_wd  = 32'hA0 + 32'(i);
            tick();
            check("stv_cpu_grant", 32'(bus.grant_dma), 32'h0);
            check("stv_cpu_adr",   bus.mem_adr, 32'h20 + 32'(i));
            check("stv_cpu_wd",    bus.mem_wd, 32'hA0 + 32'(i));
            check("stv_cnt",       32'(dut.starve_q), 32'(i + 1));
            tick();
            check("stv_cpu_ack",   32'(bus.cpu_ack), 32'h1);
            check("stv_cpu_rd",    bus.cpu_rd, 32'h0);
            tick();
        end
        bus.cpu_adr = 32'h30;
        bus.cpu_wd  = 32'hB0;
        tick();
        check("stv_dma_grant", 32'(bus.grant_dma), 32'h1);
        check("stv_dma_adr",   bus.mem_adr, 32'h10);
        check("stv_dma_cnt",   32'(dut.starve_q), 32'h0);
        tick();
        check("stv_dma_ack",  32'(bus.dma_ack), 32'h1);
        check("stv_dma_rd",   bus.dma_rd, 32'hDEADBEEF);
        check("stv_dma_cack", 32'(bus.cpu_ack), 32'h0);
        tick();
        bus.dma_req = 1'b0;
        tick();
        check("stv_cpu5_grant", 32'(bus.grant_dma), 32'h0);
        check("stv_cpu5_adr",   bus.mem_adr, 32'h30);
        tick();
        check("stv_cpu5_ack", 32'(bus.cpu_ack), 32'h1);
        tick();
        bus.cpu_req = 1'b0;
        check("stv_mem22", mem[8'h22], 32'hA2);
        check("stv_mem30", mem[8'h30], 32'hB0);

        // Reset during ISSUE aborts the access
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h10;
        tick();
        check("rab_issue_en", 32'(bus.mem_en), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rab_cack",  32'(bus.cpu_ack), 32'h0);
        check("rab_en",    32'(bus.mem_en), 32'h0);
        check("rab_adr",   bus.mem_adr, 32'h0);
        check("rab_grant", 32'(bus.grant_dma), 32'h0);
        tick();
        check("rab_re_en",  32'(bus.mem_en), 32'h1);
        check("rab_re_adr", bus.mem_adr, 32'h10);
        tick();
        check("rab_re_ack", 32'(bus.cpu_ack), 32'h1);
        check("rab_re_rd",  bus.cpu_rd, 32'hDEADBEEF);
        tick();
        bus.cpu_req = 1'b0;
        check("rab_end_ack", 32'(bus.cpu_ack), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 32, data and address width in bits.
REQ-002 Parameter: CPU_MAX, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced in (range 1..15).
REQ-003 The port list SHALL be exactly:
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  synchronous, active-low; low at a rising edge resets the block.
  cpu_req  in  1  CPU access request; held high with stable fields until cpu_ack.
  cpu_we  in  1  CPU write enable (1 = write, 0 = read).
  cpu_adr  in  DW  CPU address.
  cpu_wd  in  DW  CPU write data.
  cpu_rd  out  DW  CPU read data; valid only while cpu_ack=1.
  cpu_ack  out  1  one-cycle completion pulse to the CPU.
  dma_req, dma_we, dma_adr, dma_wd, dma_rd, dma_ack  same directions, widths and meanings as the cpu_* ports, for the DMA/loader requester.
  mem_en  out  1  memory access strobe.
  mem_we  out  1  memory write strobe.
  mem_adr  out  DW  memory address.
  mem_wd  out  DW  memory write data.
  mem_rd  in  DW  memory read data; synchronous single-port memory, valid in the cycle after mem_en.
  grant_dma  out  1  1 while the current access belongs to DMA.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-005 Transitions SHALL be: IDLE to ISSUE when cpu_req or dma_req is high, otherwise stay in IDLE; ISSUE to RESP unconditionally; RESP to IDLE unconditionally.
REQ-006 Arbitration SHALL occur only in IDLE; requests arriving in ISSUE or RESP SHALL wait until the next IDLE.
REQ-007 In IDLE, the owner is CPU if only cpu_req is high, and DMA if only dma_req is high.
REQ-008 With both requests high in IDLE, the owner SHALL be CPU unless starve_cnt equals CPU_MAX, in which case it SHALL be DMA.
REQ-009 starve_cnt (4-bit) SHALL increment on each CPU grant made while dma_req is high.
REQ-010 starve_cnt SHALL clear on any DMA grant and in any IDLE cycle where dma_req is low, and SHALL never exceed CPU_MAX.
REQ-011 On the IDLE-to-ISSUE edge, the winning requester's we/adr/wd and the owner bit SHALL be latched; later changes on the requester's inputs SHALL have no effect on the access.
REQ-012 In ISSUE: mem_en=1, mem_we=latched we, mem_adr=latched adr, mem_wd=latched wd.
REQ-013 In IDLE and RESP, mem_en, mem_we, mem_adr and mem_wd SHALL all be 0.
REQ-014 In RESP, the owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-015 The owner's rd output SHALL equal mem_rd in RESP for reads, and 0 for writes.
REQ-016 Every rd output SHALL be 0 whenever its ack is 0.
REQ-017 grant_dma SHALL equal the latched owner bit in ISSUE and RESP, and 0 in IDLE.
REQ-018 Latency: a request sampled in IDLE at edge t gives mem_en in cycle t+1 and ack in cycle t+2. Peak throughput is one access per 3 cycles.
REQ-019 A requester SHALL drop req in the cycle after its ack unless it is presenting a new access. A req high in IDLE is always treated as a new request.
REQ-020 No access SHALL be lost or duplicated; each granted request yields exactly one mem_en cycle and one ack.

Reset
REQ-021 When reset=0 at a rising edge: state becomes IDLE, starve_cnt and the latched registers become 0, and all outputs become 0 in the following cycle.
REQ-022 Reset in ISSUE or RESP SHALL abort the access with no ack. A write whose mem_en cycle has already completed is not undone.
REQ-023 The first arbitration after reset release SHALL occur in the first cycle with reset=1.

Verification
REQ-024 CPU read: cpu_req=1, cpu_we=0, cpu_adr=0x10, memory returns 0xDEADBEEF -> cycle+1 mem_en=1 with mem_adr=0x10; cycle+2 cpu_ack=1 with cpu_rd=0xDEADBEEF; dma_ack stays 0.
REQ-025 DMA write: dma_req=1, dma_we=1, dma_adr=0x40, dma_wd=0x12345678 -> cycle+1 mem_en=1, mem_we=1, mem_wd=0x12345678, grant_dma=1; cycle+2 dma_ack=1 with dma_rd=0.
REQ-026 Simultaneous requests with starve_cnt=0 -> CPU access first (acked at +2), DMA access next (mem_en at +4, dma_ack at +5).
REQ-027 Starvation: cpu_req held high continuously (new access after each ack) and dma_req high, CPU_MAX=4 -> exactly 4 CPU accesses, then one DMA access, then starve_cnt=0.
REQ-028 Capture: cpu_adr changed from 0x10 to 0x20 during ISSUE -> mem_adr stays 0x10.
REQ-029 Reset mid-access: reset=0 for one edge during ISSUE -> no ack, all outputs 0, next request served with normal +1/+2 timing.
